// File: rtl/dff.sv
// dff -- positive-edge D flip-flop with asynchronous active-low reset.
//
// This is the basic one-cycle storage element that registers, counters and
// RAM cells are built from. Every bit of q is an independent flop. All bits
// share the same clock and the same reset.
//
// Parameters:
//   WIDTH        bit width of d and q (1..64)
//   RESET_VALUE  value forced onto q while rst_n is low. Only the low WIDTH
//                bits are used, so the value is zero-extended or truncated
//                to WIDTH.
//
// Ports:
//   clk    input   1      system clock; q updates on the rising edge only
//   rst_n  input   1      asynchronous active-low reset
//   d      input   WIDTH  data sampled on the rising edge of clk
//   q      output  WIDTH  d as captured at the most recent rising edge
//
// Timing notes:
//   - Asserting rst_n forces q to RESET_VALUE at once. No clock edge is needed.
//   - Releasing rst_n leaves q unchanged. The first capture happens at the
//     first rising edge that sees rst_n high.
//   - When rst_n is released on the same rising edge, reset takes priority for
//     that edge. Recovery and removal timing must therefore be met by the user.

module dff #(
  parameter int unsigned      WIDTH       = 1,
  parameter logic [63:0]      RESET_VALUE = 64'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // RESET_VALUE is wider than any legal WIDTH, so only its low bits are kept.
  localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];

  // A plain async-reset register. Bits whose RESET_VALUE is 0 map to flops
  // with an async clear. Bits whose RESET_VALUE is 1 map to flops with an
  // async preset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_dff.sv
// tb_dff -- self-checking bench for dff.
//
// Three instances share one clock and one reset:
//   u1  WIDTH=1, RESET_VALUE=0     (the canonical DFF)
//   u8  WIDTH=8, RESET_VALUE=8'hA5
//   u4  WIDTH=4, RESET_VALUE=64'hF3 (truncated to 4'h3)
//
// The bench works through these phases in order:
//   1. Reset assertion, hold and release.
//   2. A table of vectors.
//   3. Hand-written corner cases: glitches, hold with no output event, async
//      reset in mid-cycle, and falling-edge invariance.
//   4. Randomized stimulus checked against a reference model.
//
// The reference model only states the rules. A rising edge gives q equal to
// d if rst_n is high, or RESET_VALUE if it is low. Reset assertion gives
// RESET_VALUE at once. Anything else leaves q unchanged.

`timescale 1ns/1ps

module tb_dff;

  localparam logic [7:0] RV8 = 8'hA5;
  localparam logic [3:0] RV4 = 4'h3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       d1    = 1'b1;
  logic [7:0] d8    = 8'hFF;
  logic [3:0] d4    = 4'hF;
  logic       q1;
  logic [7:0] q8;
  logic [3:0] q4;

  int checks    = 0;
  int errors    = 0;
  int q8_events = 0;

  // Rising edges occur at 5, 15, 25, ... ns.
  always #5 clk = ~clk;

  // Counts every change on q8. The hold check uses it to confirm that no
  // output event occurs.
  always @(q8) q8_events++;

  dff #(.WIDTH(1), .RESET_VALUE(64'd0))  u1 (.clk(clk), .rst_n(rst_n), .d(d1), .q(q1));
  dff #(.WIDTH(8), .RESET_VALUE(64'hA5)) u8 (.clk(clk), .rst_n(rst_n), .d(d8), .q(q8));
  dff #(.WIDTH(4), .RESET_VALUE(64'hF3)) u4 (.clk(clk), .rst_n(rst_n), .d(d4), .q(q4));

  typedef struct {
    logic       rst;
    logic       d1;
    logic [7:0] d8;
    logic [3:0] d4;
    logic       e1;
    logic [7:0] e8;
    logic [3:0] e4;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h at %0t", name, act, $time);
    end
  endtask

  // Waits for the next rising edge, then moves 1 ns past it so outputs are
  // sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic       exp1;
  logic [7:0] exp8;
  logic [3:0] exp4;
  logic       r;
  int         ev;

  initial begin
    // Vector table: inputs are applied after a falling edge. Expected values
    // are the outputs just after the following rising edge.
    vecs[0] = '{1'b1, 1'b0, 8'h3C, 4'hC, 1'b0, 8'h3C, 4'hC};
    vecs[1] = '{1'b1, 1'b1, 8'hC3, 4'h5, 1'b1, 8'hC3, 4'h5};
    vecs[2] = '{1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 4'h0};
    vecs[3] = '{1'b1, 1'b1, 8'hFF, 4'hF, 1'b1, 8'hFF, 4'hF};
    vecs[4] = '{1'b1, 1'b1, 8'hFF, 4'hF, 1'b1, 8'hFF, 4'hF};
    vecs[5] = '{1'b1, 1'b0, 8'h5A, 4'hA, 1'b0, 8'h5A, 4'hA};
    vecs[6] = '{1'b0, 1'b1, 8'h12, 4'h7, 1'b0, RV8,   RV4  };
    vecs[7] = '{1'b1, 1'b1, 8'h12, 4'h7, 1'b1, 8'h12, 4'h7};
    vecs[8] = '{1'b1, 1'b0, 8'h01, 4'h8, 1'b0, 8'h01, 4'h8};
    vecs[9] = '{1'b1, 1'b1, 8'h80, 4'h1, 1'b1, 8'h80, 4'h1};

    // ---- Reset: assert with clk low and d high. No edge is needed. ----
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_q1", 64'(q1), 64'(1'b0));
    chk("rst_async_q8", 64'(q8), 64'(RV8));
    chk("rst_async_q4_trunc", 64'(q4), 64'(RV4));

    // Reset must hold across three rising edges while d is high.
    repeat (3) begin
      tick();
      chk("rst_hold_q1", 64'(q1), 64'(1'b0));
      chk("rst_hold_q8", 64'(q8), 64'(RV8));
    end

    // Release between edges (t=32, clk low). q must not change until the
    // next rising edge.
    #6 rst_n = 1'b1;
    #1;
    chk("release_nochg_q1", 64'(q1), 64'(1'b0));
    chk("release_nochg_q8", 64'(q8), 64'(RV8));
    tick();
    chk("first_capture_q1", 64'(q1), 64'(1'b1));
    chk("first_capture_q8", 64'(q8), 64'(8'hFF));
    chk("first_capture_q4", 64'(q4), 64'(4'hF));

    // ---- Table-driven vectors ----
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst;
      d1    = vecs[i].d1;
      d8    = vecs[i].d8;
      d4    = vecs[i].d4;
      tick();
      chk($sformatf("vec%0d_q1", i), 64'(q1), 64'(vecs[i].e1));
      chk($sformatf("vec%0d_q8", i), 64'(q8), 64'(vecs[i].e8));
      chk($sformatf("vec%0d_q4", i), 64'(q4), 64'(vecs[i].e4));
    end

    // ---- Hold: d unchanged at an edge gives no output event ----
    @(negedge clk);
    d8 = 8'h66;
    tick();
    ev = q8_events;
    tick();
    chk("hold_value_q8", 64'(q8), 64'(8'h66));
    chk("hold_no_event", 64'(q8_events), 64'(ev));

    // ---- Glitch entirely between two rising edges ----
    @(negedge clk);
    d1 = 1'b0;
    tick();
    #1 d1 = 1'b1; d8 = 8'hFF;
    #2 d1 = 1'b0; d8 = 8'h66;
    tick();
    chk("glitch_q1", 64'(q1), 64'(1'b0));
    chk("glitch_q8", 64'(q8), 64'(8'h66));

    // ---- Pulse spanning a rising edge: q is high for exactly one cycle ----
    @(negedge clk);
    #2 d1 = 1'b1;
    @(posedge clk);
    #2 d1 = 1'b0;
    #1;
    chk("pulse_hi_q1", 64'(q1), 64'(1'b1));
    tick();
    chk("pulse_lo_q1", 64'(q1), 64'(1'b0));

    // ---- Async reset in mid-cycle with clk high ----
    @(negedge clk);
    d1 = 1'b1;
    d8 = 8'h81;
    tick();
    chk("premid_q1", 64'(q1), 64'(1'b1));
    chk("premid_q8", 64'(q8), 64'(8'h81));
    #2 rst_n = 1'b0;
    #1;
    chk("async_mid_q1", 64'(q1), 64'(1'b0));
    chk("async_mid_q8", 64'(q8), 64'(RV8));
    repeat (2) begin
      tick();
      chk("async_hold_q1", 64'(q1), 64'(1'b0));
      chk("async_hold_q8", 64'(q8), 64'(RV8));
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("post_mid_q1", 64'(q1), 64'(1'b1));
    chk("post_mid_q8", 64'(q8), 64'(8'h81));

    // ---- Falling edge: d changes just before the fall, q waits for the rise ----
    @(posedge clk);
    #3 d1 = 1'b0; d8 = 8'h18; d4 = 4'h9;
    @(negedge clk);
    #1;
    chk("fall_noeff_q1", 64'(q1), 64'(1'b1));
    chk("fall_noeff_q8", 64'(q8), 64'(8'h81));
    tick();
    chk("fall_rise_q1", 64'(q1), 64'(1'b0));
    chk("fall_rise_q8", 64'(q8), 64'(8'h18));
    chk("fall_rise_q4", 64'(q4), 64'(4'h9));

    // ---- Randomized stimulus against the reference model ----
    exp1 = 1'b0;
    exp8 = 8'h18;
    exp4 = 4'h9;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      #1;
      r     = ($urandom_range(0, 9) != 0);
      rst_n = r;
      d1    = 1'($urandom);
      d8    = 8'($urandom);
      d4    = 4'($urandom);
      // Between edges: an asserted reset acts at once. Otherwise q keeps the
      // value it already had.
      if (!r) begin
        exp1 = 1'b0;
        exp8 = RV8;
        exp4 = RV4;
      end
      #1;
      chk("rand_mid_q8", 64'(q8), 64'(exp8));
      // At the rising edge: capture d, or keep the reset value while reset is
      // still held.
      exp1 = r ? d1 : 1'b0;
      exp8 = r ? d8 : RV8;
      exp4 = r ? d4 : RV4;
      tick();
      chk("rand_q1", 64'(q1), 64'(exp1));
      chk("rand_q8", 64'(q8), 64'(exp8));
      chk("rand_q4", 64'(q4), 64'(exp4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
